// File: rtl/vga_seg_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_seg_display_if
//  Description : VGA raster output bundle for the 7-segment readout. The
//                display core drives it through the master modport; a DAC
//                or monitor model observes it through the slave modport.
//  Signals     : oHS      - horizontal sync, active-low
//                oVS      - vertical sync, active-low
//                oBLANK_n - high during active video
//                oVGA_R/G/B - 4-bit colour channels
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_seg_display_if;
    logic       oHS;
    logic       oVS;
    logic       oBLANK_n;
    logic [3:0] oVGA_R;
    logic [3:0] oVGA_G;
    logic [3:0] oVGA_B;

    modport master (
        output oHS,
        output oVS,
        output oBLANK_n,
        output oVGA_R,
        output oVGA_G,
        output oVGA_B
    );

    modport slave (
        input oHS,
        input oVS,
        input oBLANK_n,
        input oVGA_R,
        input oVGA_G,
        input oVGA_B
    );
endinterface
`default_nettype wire

// File: rtl/vga_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : vga_seg_display
//  Description : 640x480@60 VGA readout that shows an unsigned binary value
//                as NUM_DIGITS decimal 7-segment digits. Owns the raster
//                timing, converts the value once per frame with a
//                sequential double-dabble engine during vertical blanking,
//                and drives a 2-stage pixel pipeline (sync/blank aligned
//                with colour).
//  Ports       : iVGA_CLK - pixel clock (25.175 MHz nominal)
//                iRST_n   - asynchronous active-low reset
//                iValue   - value to show, sampled at (h=0, v=480)
//                oFrame   - one-cycle pulse when iValue is captured
//                oBusy    - high while the BCD conversion runs
//                vga      - raster outputs (HS, VS, BLANK_n, R, G, B)
//  Options     : VGA_SEG_LZB_EN - when defined, leading zeros are blanked
//                (the last digit is always shown, overflow dashes are never
//                blanked). Undefined: every digit is always shown.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_seg_display #(
    parameter int          NUM_DIGITS  = 3,
    parameter int          VAL_W       = 32,
    parameter int          X0          = 70,
    parameter int          Y0          = 150,
    parameter int          DIGIT_PITCH = 160,
    parameter int          SEG_T       = 20,
    parameter int          SEG_L       = 60,
    parameter logic [11:0] FG_RGB      = 12'hFFF,
    parameter logic [11:0] BG_RGB      = 12'h070
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic [VAL_W-1:0]  iValue,
    output logic              oFrame,
    output logic              oBusy,
    vga_seg_display_if.master vga
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BCD_W = 4 * NUM_DIGITS;
    localparam int c_CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(VAL_W - 1);

    localparam int c_T = SEG_T;
    localparam int c_L = SEG_L;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Values at or above this limit cannot be shown and render as dashes.
    // For a narrow VAL_W the limit exceeds every representable value.
    localparam logic [63:0] c_POW10 = pow10(NUM_DIGITS);

    // Half-open interval test; negative coordinates miss because every
    // lower bound is non-negative.
    function automatic logic in_rng(input int x, input int lo, input int hi);
        return (x >= lo) && (x < hi);
    endfunction

    // Segment order {a,b,c,d,e,f,g}, active-high. Codes above 9 stay dark.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } conv_state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // raster counters
    logic [9:0]             h_q, h_d;
    logic [9:0]             v_q, v_d;
    // pipeline stage 1
    logic [9:0]             h1_q, h1_d;
    logic [9:0]             v1_q, v1_d;
    logic                   hs1_q, hs1_d;
    logic                   vs1_q, vs1_d;
    logic                   act1_q, act1_d;
    // pipeline stage 2 (output registers)
    logic                   hs2_q, hs2_d;
    logic                   vs2_q, vs2_d;
    logic                   act2_q, act2_d;
    logic [11:0]            rgb_q, rgb_d;
    // converter
    conv_state_t            state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [VAL_W-1:0]       bin_q, bin_d;
    logic [c_BCD_W-1:0]     bcd_q, bcd_d;
    logic                   ovf_cap_q, ovf_cap_d;
    logic                   frame_q, frame_d;
    // display registers, written only in S_LOAD
    logic [c_BCD_W-1:0]     digit_q, digit_d;
    logic [NUM_DIGITS-1:0]  blank_q, blank_d;
    logic                   ovf_q, ovf_d;

    // ------------------------------------------------------------------------
    // Raster timing
    // ------------------------------------------------------------------------
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == 10'd799) begin
            h_d = 10'd0;
            v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    always_comb begin
        h1_d   = h_q;
        v1_d   = v_q;
        hs1_d  = !((h_q >= 10'd656) && (h_q < 10'd752));
        vs1_d  = !((v_q >= 10'd490) && (v_q < 10'd492));
        act1_d = (h_q < 10'd640) && (v_q < 10'd480);
    end

    // ------------------------------------------------------------------------
    // Capture and double-dabble converter
    // ------------------------------------------------------------------------
    logic                   w_capture;
    logic [63:0]            w_val64;
    logic                   w_ovf_in;
    logic [c_BCD_W-1:0]     w_bcd_adj;
    logic [NUM_DIGITS-1:0]  w_zero;
    logic [NUM_DIGITS-1:0]  w_lzb;

    assign w_capture = (h_q == 10'd0) && (v_q == 10'd480);
    assign w_val64   = 64'(iValue);
    assign w_ovf_in  = (w_val64 >= c_POW10);

    // Add-3 correction on every nibble that would exceed 9 after the shift.
    // Nibble 0 is the least significant decimal digit.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        assign w_bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                                     bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        // w_zero is indexed by display position (0 = leftmost).
        assign w_zero[i] = (bcd_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
    end

`ifdef VGA_SEG_LZB_EN
    // A digit is blank when it and every digit to its left are zero; the
    // rightmost digit always shows and dashes are never blanked.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lzb
        if (i < NUM_DIGITS - 1) begin : g_lead
            assign w_lzb[i] = (&w_zero[i:0]) & ~ovf_cap_q;
        end else begin : g_last
            assign w_lzb[i] = 1'b0;
        end
    end
`else
    assign w_lzb = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_cap_d = ovf_cap_q;
        frame_d   = 1'b0;
        digit_d   = digit_q;
        blank_d   = blank_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (w_capture) begin
                    bin_d     = iValue;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_cap_d = w_ovf_in;
                    frame_d   = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = {w_bcd_adj[c_BCD_W-2:0], bin_q[VAL_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Single update point for everything the pixel path reads,
                // which lands in vertical blanking, so a frame never tears.
                digit_d = bcd_q;
                ovf_d   = ovf_cap_q;
                blank_d = w_lzb;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Segment hit test (operates on stage-1 coordinates)
    // ------------------------------------------------------------------------
    int                    w_ly;
    logic [NUM_DIGITS-1:0] w_hit;

    assign w_ly = int'(v1_q) - Y0;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        localparam int c_ORG = X0 + d * DIGIT_PITCH;
        int         w_lx;
        logic [6:0] w_seg_on;
        logic [6:0] w_seg_in;

        assign w_lx = int'(h1_q) - c_ORG;

        assign w_seg_on = ovf_q      ? 7'b0000001 :
                          blank_q[d] ? 7'b0000000 :
                          seg7(digit_q[4*(NUM_DIGITS-1-d) +: 4]);

        assign w_seg_in[6] = in_rng(w_lx, c_T, c_T + c_L) &&
                             in_rng(w_ly, 0, c_T);
        assign w_seg_in[5] = in_rng(w_lx, c_T + c_L, 2*c_T + c_L) &&
                             in_rng(w_ly, 0, c_L + 2*c_T);
        assign w_seg_in[4] = in_rng(w_lx, c_T + c_L, 2*c_T + c_L) &&
                             in_rng(w_ly, c_L + c_T, 2*c_L + 3*c_T);
        assign w_seg_in[3] = in_rng(w_lx, c_T, c_T + c_L) &&
                             in_rng(w_ly, 2*c_L + 2*c_T, 2*c_L + 3*c_T);
        assign w_seg_in[2] = in_rng(w_lx, 0, c_T) &&
                             in_rng(w_ly, c_L + c_T, 2*c_L + 3*c_T);
        assign w_seg_in[1] = in_rng(w_lx, 0, c_T) &&
                             in_rng(w_ly, 0, c_L + 2*c_T);
        assign w_seg_in[0] = in_rng(w_lx, c_T, c_T + c_L) &&
                             in_rng(w_ly, c_T + c_L, 2*c_T + c_L);

        assign w_hit[d] = |(w_seg_in & w_seg_on);
    end

    always_comb begin
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        act2_d = act1_q;
        rgb_d  = 12'h000;
        if (act1_q) begin
            rgb_d = (|w_hit) ? FG_RGB : BG_RGB;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_q       <= '0;
            v_q       <= '0;
            h1_q      <= '0;
            v1_q      <= '0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            act1_q    <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            act2_q    <= 1'b0;
            rgb_q     <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_cap_q <= 1'b0;
            frame_q   <= 1'b0;
            digit_q   <= '0;
            blank_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            h1_q      <= h1_d;
            v1_q      <= v1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            act1_q    <= act1_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            act2_q    <= act2_d;
            rgb_q     <= rgb_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_cap_q <= ovf_cap_d;
            frame_q   <= frame_d;
            digit_q   <= digit_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vga.oHS      = hs2_q;
    assign vga.oVS      = vs2_q;
    assign vga.oBLANK_n = act2_q;
    assign vga.oVGA_R   = rgb_q[11:8];
    assign vga.oVGA_G   = rgb_q[7:4];
    assign vga.oVGA_B   = rgb_q[3:0];
    assign oFrame       = frame_q;
    assign oBusy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_seg_display
//  Description : Self-checking bench for vga_seg_display (default
//                parameters). A raster-level model predicts every output on
//                every clock from the elapsed cycle count and the value the
//                display should be showing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_seg_display;
    localparam int          N     = 3;
    localparam int          VW    = 32;
    localparam int          X0    = 70;
    localparam int          Y0    = 150;
    localparam int          PITCH = 160;
    localparam int          T     = 20;
    localparam int          L     = 60;
    localparam logic [11:0] FG    = 12'hFFF;
    localparam logic [11:0] BG    = 12'h070;
    localparam longint      FRAME = 800 * 525;
    localparam longint      CAP   = 480 * 800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] value = '0;
    logic          frame;
    logic          busy;

    vga_seg_display_if vif ();

    vga_seg_display #(
        .NUM_DIGITS (N),
        .VAL_W      (VW),
        .X0         (X0),
        .Y0         (Y0),
        .DIGIT_PITCH(PITCH),
        .SEG_T      (T),
        .SEG_L      (L),
        .FG_RGB     (FG),
        .BG_RGB     (BG)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n  (rst_n),
        .iValue  (value),
        .oFrame  (frame),
        .oBusy   (busy),
        .vga     (vif)
    );

    always #20 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint k;          // clock edges since reset release
    longint disp_val;   // value the model expects on screen
    string  segs [10];

    function automatic longint p10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit seg_lit(input int dig, input byte c);
        string s;
        s = segs[dig];
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit in_seg(input byte c, input int lx, input int ly);
        case (c)
            "a": return lx >= T     && lx < T+L   && ly >= 0     && ly < T;
            "b": return lx >= T+L   && lx < 2*T+L && ly >= 0     && ly < L+2*T;
            "c": return lx >= T+L   && lx < 2*T+L && ly >= L+T   && ly < 2*L+3*T;
            "d": return lx >= T     && lx < T+L   && ly >= 2*L+2*T && ly < 2*L+3*T;
            "e": return lx >= 0     && lx < T     && ly >= L+T   && ly < 2*L+3*T;
            "f": return lx >= 0     && lx < T     && ly >= 0     && ly < L+2*T;
            "g": return lx >= T     && lx < T+L   && ly >= T+L   && ly < 2*T+L;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit pixel_lit(input int h, input int v, input longint val);
        string  names;
        bit     ovf;
        bit     lead;
        bit     blank;
        bit     on;
        int     dig;
        int     lx;
        int     ly;
        names = "abcdefg";
        ovf   = (val >= p10(N));
        lead  = 1'b1;
        ly    = v - Y0;
        if (ly < 0 || ly >= 2*L + 3*T) return 1'b0;
        for (int d = 0; d < N; d++) begin
            dig   = int'((val / p10(N-1-d)) % 10);
            blank = 1'b0;
`ifdef VGA_SEG_LZB_EN
            lead  = lead && (dig == 0);
            blank = lead && (d < N-1) && !ovf;
`endif
            lx = h - (X0 + d * PITCH);
            for (int s = 0; s < 7; s++) begin
                on = ovf ? (names[s] == "g") : (!blank && seg_lit(dig, names[s]));
                if (on && in_seg(names[s], lx, ly)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic step();
        logic [16:0] exp_v;
        logic [16:0] obs_v;
        logic [11:0] rgb;
        longint      p;
        longint      fpos;
        int          h;
        int          v;
        bit          act;
        bit          fr;
        bit          bz;
        @(posedge clk);
        k++;
        @(negedge clk);
        fpos = (k - 1) % FRAME;
        fr   = (fpos == CAP);
        bz   = (fpos >= CAP) && (fpos < CAP + VW + 1);
        if (fr) disp_val = {32'b0, value};
        h = 0;
        v = 0;
        if (k < 2) begin
            exp_v = {1'b1, 1'b1, 1'b0, 12'h000, fr, bz};
        end else begin
            p   = (k - 2) % FRAME;
            h   = int'(p % 800);
            v   = int'(p / 800);
            act = (h < 640) && (v < 480);
            rgb = !act ? 12'h000 : (pixel_lit(h, v, disp_val) ? FG : BG);
            exp_v = {!(h >= 656 && h < 752), !(v >= 490 && v < 492), act, rgb, fr, bz};
        end
        obs_v = {vif.oHS, vif.oVS, vif.oBLANK_n, vif.oVGA_R, vif.oVGA_G, vif.oVGA_B,
                 frame, busy};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL raster k=%0d h=%0d v=%0d observed=%h expected=%h",
                   k, h, v, obs_v, exp_v);
        end
    endtask

    task automatic run(input longint n);
        for (longint i = 0; i < n && errors < 20; i++) step();
    endtask

    task automatic check_reset(input string tag);
        logic [16:0] obs_v;
        obs_v = {vif.oHS, vif.oVS, vif.oBLANK_n, vif.oVGA_R, vif.oVGA_G, vif.oVGA_B,
                 frame, busy};
        checks++;
        assert (obs_v === {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v,
                   {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0});
        end
    endtask

    initial begin
        segs = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                 "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
        k        = 0;
        disp_val = 0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");

        // First frame shows 000, then a random in-range value is captured.
        value = VW'($urandom_range(1, 999));
        rst_n = 1'b1;
        run(CAP + 101);

        // Changing the input mid-frame must not disturb the shown value.
        value = $urandom;
        run(FRAME - 95);

        // Now five cycles into the second conversion: abort it with reset.
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL busy_before_abort observed=%b expected=1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_reset("async_reset_mid_shift");
        k        = 0;
        disp_val = 0;
        @(negedge clk);
        check_reset("reset_hold");

        // After release: 000 frame, capture exactly 384000 cycles later with
        // an over-range value, then dashes on the next frame.
        value = 32'd1000 + $urandom_range(0, 32'h7FFF0000);
        rst_n = 1'b1;
        run(FRAME + 360 * 800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
